// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared types and width helpers for the bomb engine
package bomb_pkg;

    typedef enum logic [2:0] {
        PLAY,
        DECR,
        RESOLVE,
        DAMAGE,
        CHECK,
        OVER
    } engineState;

    localparam int WINNER_W = 3;

    function automatic int widthOf(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int coordWidth(input int w, input int h);
        return widthOf((w > h) ? w : h);
    endfunction

    function automatic int healthWidth(input int healthInit);
        return widthOf(healthInit + 1);
    endfunction

    function automatic int cellIdx(input int x, input int y, input int gridW);
        return y * gridW + x;
    endfunction

endpackage

// File: rtl/bomb_if.sv
// rtl/bomb_if.sv - placement handshake and player positions from chara_control
interface bomb_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int CW          = 4
);
    logic [NUM_PLAYERS-1:0]    place_req;
    logic [NUM_PLAYERS-1:0]    place_ack;
    logic [NUM_PLAYERS-1:0]    place_nack;
    logic [NUM_PLAYERS*CW-1:0] player_x;
    logic [NUM_PLAYERS*CW-1:0] player_y;

    modport master (output place_req, player_x, player_y, input place_ack, place_nack);
    modport slave  (input place_req, player_x, player_y, output place_ack, place_nack);
endinterface

// File: rtl/bomb_blast_ray.sv
// rtl/bomb_blast_ray.sv - combinational cross painter for one detonation
// Each of the four rays stops at the first wall or grid edge; the centre is always painted.
module bomb_blast_ray
    import bomb_pkg::*;
#(
    parameter int GRID_W       = 10,
    parameter int GRID_H       = 10,
    parameter int BLAST_RADIUS = 2,
    parameter int CW           = 4
) (
    input  logic [CW-1:0]            centreX,
    input  logic [CW-1:0]            centreY,
    input  logic [GRID_W*GRID_H-1:0] wallMap,
    output logic [GRID_W*GRID_H-1:0] mask
);
    localparam int IW = widthOf(GRID_W * GRID_H);

    int             nx;
    int             ny;
    logic           go;
    logic [IW-1:0]  idx;

    always_comb begin
        mask = '0;
        nx   = 0;
        ny   = 0;
        go   = 1'b0;
        idx  = '0;
        if (int'(centreX) < GRID_W && int'(centreY) < GRID_H) begin
            mask[IW'(cellIdx(int'(centreX), int'(centreY), GRID_W))] = 1'b1;
            for (int d = 0; d < 4; d++) begin
                go = 1'b1;
                for (int r = 1; r <= BLAST_RADIUS; r++) begin
                    nx  = int'(centreX) + ((d == 0) ? r : (d == 1) ? -r : 0);
                    ny  = int'(centreY) + ((d == 2) ? r : (d == 3) ? -r : 0);
                    idx = IW'(cellIdx(nx, ny, GRID_W));
                    if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) go = 1'b0;
                    else if (wallMap[idx]) go = 1'b0;
                    if (go) mask[idx] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/bomb_engine.sv
// rtl/bomb_engine.sv - bomb slot table, fuse countdown, chained blasts, damage and game-over
// A tick walks DECR -> RESOLVE (one slot per cycle, repeated passes for chains) -> DAMAGE -> CHECK.
module bomb_engine
    import bomb_pkg::*;
#(
    parameter int  GRID_W       = 10,
    parameter int  GRID_H       = 10,
    parameter int  NUM_PLAYERS  = 2,
    parameter int  MAX_BOMBS    = 4,
    parameter int  FUSE_TICKS   = 3,
    parameter int  BLAST_RADIUS = 2,
    parameter int  HEALTH_INIT  = 3,
    localparam int CW           = coordWidth(GRID_W, GRID_H),
    localparam int HW           = healthWidth(HEALTH_INIT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic [GRID_W*GRID_H-1:0]  wall_map,
    bomb_if.slave                     bus,
    output logic [GRID_W*GRID_H-1:0]  bomb_map,
    output logic [GRID_W*GRID_H-1:0]  blast_map,
    output logic [NUM_PLAYERS*HW-1:0] health,
    output logic                      busy,
    output logic                      game_over,
    output logic                      draw,
    output logic [WINNER_W-1:0]       winner
);
    localparam int IW = widthOf(GRID_W * GRID_H);
    localparam int PW = widthOf(NUM_PLAYERS);
    localparam int SW = widthOf(MAX_BOMBS);
    localparam int FW = widthOf(FUSE_TICKS + 1);

    engineState             state, stateNext;
    logic                   sValid [MAX_BOMBS];
    logic                   sExp   [MAX_BOMBS];
    logic [CW-1:0]          sX     [MAX_BOMBS];
    logic [CW-1:0]          sY     [MAX_BOMBS];
    logic [FW-1:0]          sFuse  [MAX_BOMBS];
    logic [IW-1:0]          sCell  [MAX_BOMBS];
    logic [HW-1:0]          hp     [NUM_PLAYERS];
    logic [CW-1:0]          px     [NUM_PLAYERS];
    logic [CW-1:0]          py     [NUM_PLAYERS];
    logic [IW-1:0]          pCell  [NUM_PLAYERS];
    logic                   pIn    [NUM_PLAYERS];
    logic [SW-1:0]          rIdx, passCnt, freeIdx;
    logic                   newFlag, tickPend;
    logic [NUM_PLAYERS-1:0] cand;
    logic [PW-1:0]          sel, aliveIdx;
    logic [PW:0]            aliveCnt;
    logic                   reqFound, freeFound, placeOk, anyExpire;
    logic                   curPaint, chainAny, passDone, morePass;
    logic [MAX_BOMBS-1:0]   chainHit;
    logic [GRID_W*GRID_H-1:0] rayMask;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : gPlayer
        assign px[g]               = bus.player_x[g*CW +: CW];
        assign py[g]               = bus.player_y[g*CW +: CW];
        assign pIn[g]              = (int'(px[g]) < GRID_W) && (int'(py[g]) < GRID_H);
        assign pCell[g]            = IW'(cellIdx(int'(px[g]), int'(py[g]), GRID_W));
        assign health[g*HW +: HW]  = hp[g];
    end

    for (genvar g = 0; g < MAX_BOMBS; g++) begin : gSlot
        assign sCell[g] = IW'(cellIdx(int'(sX[g]), int'(sY[g]), GRID_W));
    end

    bomb_blast_ray #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .BLAST_RADIUS(BLAST_RADIUS), .CW(CW)
    ) uRay (
        .centreX(sX[rIdx]), .centreY(sY[rIdx]), .wallMap(wall_map), .mask(rayMask)
    );

    // A request whose response is on the bus this cycle is already served; masking it
    // stops a requester that drops req on seeing ack from being serviced twice.
    always_comb begin
        cand      = bus.place_req & ~(bus.place_ack | bus.place_nack);
        reqFound  = 1'b0;
        sel       = '0;
        freeFound = 1'b0;
        freeIdx   = '0;
        anyExpire = 1'b0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--)
            if (cand[p]) begin reqFound = 1'b1; sel = PW'(p); end
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            if (!sValid[i]) begin freeFound = 1'b1; freeIdx = SW'(i); end
            if (sValid[i] && sFuse[i] == FW'(1)) anyExpire = 1'b1;
        end
        placeOk = pIn[sel] && freeFound && !wall_map[pCell[sel]] && !bomb_map[pCell[sel]];
    end

    always_comb begin
        curPaint = sValid[rIdx] && sExp[rIdx];
        for (int j = 0; j < MAX_BOMBS; j++)
            chainHit[j] = curPaint && sValid[j] && !sExp[j] && rayMask[sCell[j]];
        chainAny = newFlag || (|chainHit);
        passDone = (rIdx == SW'(MAX_BOMBS - 1));
        morePass = chainAny && (passCnt != SW'(MAX_BOMBS - 1));
        aliveCnt = '0;
        aliveIdx = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (hp[p] != '0) begin aliveCnt = aliveCnt + 1'b1; aliveIdx = PW'(p); end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PLAY;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            PLAY:    if (tick || tickPend) stateNext = DECR;
            DECR:    stateNext = anyExpire ? RESOLVE : PLAY;
            RESOLVE: if (passDone && !morePass) stateNext = DAMAGE;
            DAMAGE:  stateNext = CHECK;
            CHECK:   if (aliveCnt <= 1) stateNext = OVER;
                     else              stateNext = tickPend ? DECR : PLAY;
            OVER:    stateNext = OVER;
            default: stateNext = PLAY;
        endcase
    end

    always_comb begin
        busy = (state != PLAY) && (state != OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.place_ack  <= '0;
            bus.place_nack <= '0;
            bomb_map       <= '0;
            blast_map      <= '0;
            game_over      <= 1'b0;
            draw           <= 1'b0;
            winner         <= '0;
            rIdx           <= '0;
            passCnt        <= '0;
            newFlag        <= 1'b0;
            tickPend       <= 1'b0;
            for (int i = 0; i < MAX_BOMBS; i++) begin
                sValid[i] <= 1'b0;
                sExp[i]   <= 1'b0;
                sX[i]     <= '0;
                sY[i]     <= '0;
                sFuse[i]  <= '0;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) hp[p] <= HW'(HEALTH_INIT);
        end else begin
            bus.place_ack  <= '0;
            bus.place_nack <= '0;
            if (tick && busy)            tickPend <= 1'b1;
            else if (stateNext == DECR)  tickPend <= 1'b0;
            case (state)
                PLAY: if (reqFound) begin
                    if (placeOk) begin
                        bus.place_ack[sel]   <= 1'b1;
                        sValid[freeIdx]      <= 1'b1;
                        sExp[freeIdx]        <= 1'b0;
                        sX[freeIdx]          <= px[sel];
                        sY[freeIdx]          <= py[sel];
                        sFuse[freeIdx]       <= FW'(FUSE_TICKS);
                        bomb_map[pCell[sel]] <= 1'b1;
                    end else begin
                        bus.place_nack[sel]  <= 1'b1;
                    end
                end
                DECR: begin
                    blast_map <= '0;
                    rIdx      <= '0;
                    passCnt   <= '0;
                    newFlag   <= 1'b0;
                    for (int i = 0; i < MAX_BOMBS; i++)
                        if (sValid[i]) begin
                            sFuse[i] <= sFuse[i] - 1'b1;
                            if (sFuse[i] == FW'(1)) sExp[i] <= 1'b1;
                        end
                end
                RESOLVE: begin
                    if (curPaint) begin
                        blast_map             <= blast_map | rayMask;
                        sValid[rIdx]          <= 1'b0;
                        sExp[rIdx]            <= 1'b0;
                        bomb_map[sCell[rIdx]] <= 1'b0;
                    end
                    for (int j = 0; j < MAX_BOMBS; j++)
                        if (chainHit[j]) sExp[j] <= 1'b1;
                    if (passDone) begin
                        rIdx    <= '0;
                        passCnt <= passCnt + 1'b1;
                        newFlag <= 1'b0;
                    end else begin
                        rIdx    <= rIdx + 1'b1;
                        newFlag <= chainAny;
                    end
                end
                DAMAGE: begin
                    for (int p = 0; p < NUM_PLAYERS; p++)
                        if (hp[p] != '0 && pIn[p] && blast_map[pCell[p]]) hp[p] <= hp[p] - 1'b1;
                end
                CHECK: begin
                    if (aliveCnt == '0) begin
                        game_over <= 1'b1;
                        draw      <= 1'b1;
                    end else if (aliveCnt == 1) begin
                        game_over <= 1'b1;
                        winner    <= WINNER_W'(aliveIdx);
                    end
                end
                OVER: bus.place_nack <= cand;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bomb_engine.sv
// tb/tb_bomb_engine.sv - directed self-checking bench for bomb_engine
module tb_bomb_engine;
    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [99:0]  wallMap;
    logic [99:0]  bombMap;
    logic [99:0]  blastMap;
    logic [3:0]   health;
    logic         busy;
    logic         gameOver;
    logic         draw;
    logic [2:0]   winner;
    logic [99:0]  expBlast;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    bomb_if #(.NUM_PLAYERS(2), .CW(4)) bus ();

    bomb_engine #(
        .GRID_W(10), .GRID_H(10), .NUM_PLAYERS(2), .MAX_BOMBS(4),
        .FUSE_TICKS(3), .BLAST_RADIUS(2), .HEALTH_INIT(3)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .wall_map(wallMap), .bus(bus),
        .bomb_map(bombMap), .blast_map(blastMap), .health(health), .busy(busy),
        .game_over(gameOver), .draw(draw), .winner(winner)
    );

    function automatic logic [99:0] cellBit(input int x, input int y);
        return 100'(1) << (y * 10 + x);
    endfunction

    task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setPos(input int x0, input int y0, input int x1, input int y1);
        bus.player_x = {4'(x1), 4'(x0)};
        bus.player_y = {4'(y1), 4'(y0)};
    endtask

    task automatic place(input logic [1:0] who, input logic expAck, input string tag);
        bus.place_req = who;
        @(negedge clk);
        chk(tag, 100'({bus.place_ack, bus.place_nack}),
            expAck ? 100'({who, 2'b00}) : 100'({2'b00, who}));
        bus.place_req = 2'b00;
        @(negedge clk);
    endtask

    task automatic doTick(input string tag);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk({tag, " busy"}, 100'(busy), 100'(1));
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        chk({tag, " idle"}, 100'(busy), 100'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        bus.place_req = 2'b00;
        setPos(1, 1, 7, 7);
        wallMap = cellBit(5, 5);
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                if (x == 0 || x == 9 || y == 0 || y == 9) wallMap = wallMap | cellBit(x, y);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst bomb_map", bombMap, 100'(0));
        chk("rst blast_map", blastMap, 100'(0));
        chk("rst health", 100'(health), 100'(4'hF));
        chk("rst busy", 100'(busy), 100'(0));
        chk("rst game_over", 100'(gameOver), 100'(0));
        chk("rst draw", 100'(draw), 100'(0));
        chk("rst winner", 100'(winner), 100'(0));
        chk("rst ack/nack", 100'({bus.place_ack, bus.place_nack}), 100'(0));

        // single bomb at (1,1), walls on the border clip the up/left rays
        place(2'b01, 1'b1, "p0 place 1,1");
        chk("bomb_map 1,1", bombMap, cellBit(1, 1));
        doTick("t1a");
        doTick("t1b");
        chk("no blast before fuse", blastMap, 100'(0));
        doTick("t1c");
        expBlast = cellBit(1, 1) | cellBit(2, 1) | cellBit(3, 1) | cellBit(1, 2) | cellBit(1, 3);
        chk("blast 1,1", blastMap, expBlast);
        chk("bomb cleared", bombMap, 100'(0));
        chk("p0 damaged", 100'(health), 100'(4'hE));

        // simultaneous requests: lowest index first, one per cycle
        setPos(3, 3, 7, 7);
        bus.place_req = 2'b11;
        @(negedge clk);
        chk("dual first", 100'({bus.place_ack, bus.place_nack}), 100'(4'b0100));
        bus.place_req = 2'b10;
        @(negedge clk);
        chk("dual second", 100'({bus.place_ack, bus.place_nack}), 100'(4'b1000));
        bus.place_req = 2'b00;
        @(negedge clk);
        chk("dual bombs", bombMap, cellBit(3, 3) | cellBit(7, 7));

        place(2'b01, 1'b0, "occupied nack");
        setPos(5, 5, 7, 7);
        place(2'b01, 1'b0, "wall nack");
        setPos(12, 3, 7, 7);
        place(2'b01, 1'b0, "off grid nack");
        setPos(3, 5, 7, 7);
        place(2'b01, 1'b1, "slot2 ack");
        setPos(6, 3, 7, 7);
        place(2'b01, 1'b1, "slot3 ack");
        setPos(2, 6, 7, 7);
        place(2'b01, 1'b0, "table full nack");
        chk("four bombs", bombMap, cellBit(3, 3) | cellBit(7, 7) | cellBit(3, 5) | cellBit(6, 3));

        setPos(8, 1, 7, 7);
        doTick("t2a");
        doTick("t2b");
        doTick("t2c");
        chk("all cleared", bombMap, 100'(0));
        chk("health after four", 100'(health), 100'(4'hA));
        chk("ray reaches 8,7", 100'(blastMap[78]), 100'(1));
        chk("ray stops at wall 9,7", 100'(blastMap[79]), 100'(0));
        chk("wall 5,5 unpainted", 100'(blastMap[55]), 100'(0));

        // chain: A at (2,2) one tick from expiry sets off fresh B at (4,2)
        setPos(2, 2, 7, 7);
        place(2'b01, 1'b1, "bomb A");
        doTick("t3a");
        doTick("t3b");
        setPos(2, 2, 4, 2);
        place(2'b10, 1'b1, "bomb B");
        chk("A and B live", bombMap, cellBit(2, 2) | cellBit(4, 2));
        doTick("t3c");
        expBlast = cellBit(2, 2) | cellBit(3, 2) | cellBit(4, 2) | cellBit(1, 2) | cellBit(2, 1) |
                   cellBit(2, 3) | cellBit(2, 4) | cellBit(5, 2) | cellBit(6, 2) | cellBit(4, 1) |
                   cellBit(4, 3) | cellBit(4, 4);
        chk("chain blast", blastMap, expBlast);
        chk("chain cleared", bombMap, 100'(0));
        chk("chain health", 100'(health), 100'(4'h5));
        chk("no game over yet", 100'(gameOver), 100'(0));

        // both players at health 1 caught in one blast -> draw
        setPos(2, 2, 3, 2);
        place(2'b01, 1'b1, "final bomb");
        doTick("t4a");
        doTick("t4b");
        doTick("t4c");
        expBlast = cellBit(2, 2) | cellBit(3, 2) | cellBit(4, 2) | cellBit(1, 2) | cellBit(2, 1) |
                   cellBit(2, 3) | cellBit(2, 4);
        chk("draw game_over", 100'(gameOver), 100'(1));
        chk("draw flag", 100'(draw), 100'(1));
        chk("draw winner", 100'(winner), 100'(0));
        chk("draw health", 100'(health), 100'(0));
        chk("draw blast", blastMap, expBlast);
        place(2'b10, 1'b0, "over nack");
        chk("over bomb_map frozen", bombMap, 100'(0));
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("over busy", 100'(busy), 100'(0));
        chk("over blast frozen", blastMap, expBlast);

        // reset in the middle of RESOLVE
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("new game health", 100'(health), 100'(4'hF));
        place(2'b01, 1'b1, "new game bomb");
        doTick("t5a");
        doTick("t5b");
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk("in resolve busy", 100'(busy), 100'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst health", 100'(health), 100'(4'hF));
        chk("mid rst bomb_map", bombMap, 100'(0));
        chk("mid rst blast_map", blastMap, 100'(0));
        chk("mid rst busy", 100'(busy), 100'(0));
        chk("mid rst game_over", 100'(gameOver), 100'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post rst idle", 100'(busy), 100'(0));
        place(2'b01, 1'b1, "post rst place");
        chk("post rst bomb", bombMap, cellBit(2, 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
